mux_scan_ctrl: RTL and testbench

Scan sequencer that sits directly upstream and downstream of the 2-bit 4:1 select mux. It drives the mux select in a fixed 0→1→2→3 rotation and generates active-low digit enables with a blanking gap between digits. It samples the mux output once per digit and publishes a complete 8-bit frame with a one-cycle valid pulse after every full rotation.

---
 rtl/scan_pkg.sv | 23 ++
 rtl/scan_timer.sv | 37 +++
 rtl/mux_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_mux_scan_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the mux scan sequencer: state encoding, digit
// geometry and the active-low digit-enable decode.
package scan_pkg;

  localparam int NDIG = 4;
  localparam int DW   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_e;

  // Active-low enable for digit k: only bit k may go low, and only if masked in
  function automatic logic [NDIG-1:0] an_decode(input logic [DW-1:0]   k,
                                                input logic [NDIG-1:0] mask);
    logic [NDIG-1:0] an;
    an    = '1;
    an[k] = ~mask[k];
    return an;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter that times each BLANK/DRIVE phase. Loading N-1 on
// phase entry makes done rise on the N-th cycle of the phase.
module scan_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load wins over counting; the counter parks at zero until reloaded
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 select mux: rotates sel 0..3, drives active-low
// digit enables with an optional blanking gap, samples the mux once per
// digit and publishes a full frame with a one-cycle valid pulse.
module mux_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL = 50000,
  parameter int BLANK = 500,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NDIG-1:0]    digit_mask,
  input  logic [DW-1:0]      mux_o,
  output logic [DW-1:0]      sel,
  output logic [NDIG-1:0]    an,
  output logic [NDIG*DW-1:0] frame,
  output logic               frame_valid
);

  localparam bit               HAS_BLANK = (BLANK > 0);
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LD  = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  state_e                   state_q, state_d;
  logic [DW-1:0]            sel_q, sel_d;
  logic [NDIG-1:0]          an_q, an_d;
  logic [(NDIG-1)*DW-1:0]   shadow_q, shadow_d;
  logic [NDIG*DW-1:0]       frame_q, frame_d;
  logic                     fv_q, fv_d;

  logic                     tmr_load;
  logic [CNT_W-1:0]         tmr_val;
  logic                     tmr_done;

  scan_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and timer reload; every phase entry reloads the timer
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d  = HAS_BLANK ? S_BLANK : S_DRIVE;
          tmr_load = 1'b1;
        end
        S_BLANK: begin
          if (tmr_done) begin
            state_d  = S_DRIVE;
            tmr_load = 1'b1;
          end
        end
        S_DRIVE: begin
          if (tmr_done) begin
            state_d  = HAS_BLANK ? S_BLANK : S_DRIVE;
            tmr_load = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    tmr_val = (state_d == S_BLANK) ? BLANK_LD : DWELL_LD;
  end

  // Outputs: sel advance, mux sampling into shadow/frame, an decode
  always_comb begin
    sel_d    = sel_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    fv_d     = 1'b0;
    if (!en || state_q == S_IDLE) begin
      sel_d    = '0;
      shadow_d = '0;
    end else if (state_q == S_DRIVE && tmr_done) begin
      unique case (sel_q)
        2'd0: shadow_d[1:0] = mux_o;
        2'd1: shadow_d[3:2] = mux_o;
        2'd2: shadow_d[5:4] = mux_o;
        default: begin
          frame_d = {mux_o, shadow_q};
          fv_d    = 1'b1;
        end
      endcase
      sel_d = (sel_q == DW'(NDIG - 1)) ? '0 : sel_q + DW'(1);
    end
    an_d = (state_d == S_DRIVE) ? an_decode(sel_d, digit_mask) : '1;
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      an_q     <= '1;
      shadow_q <= '0;
      frame_q  <= '0;
      fv_q     <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      an_q     <= an_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      fv_q     <= fv_d;
    end
  end

  assign sel         = sel_q;
  assign an          = an_q;
  assign frame       = frame_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: instance A uses DWELL=4/BLANK=2,
// instance B uses DWELL=1/BLANK=0. The mux model returns
// mux_map[2*sel+1:2*sel], so a complete frame equals mux_map.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en_a, en_b;
  logic [3:0] mask_a, mask_b;
  logic [7:0] map_a, map_b;
  logic [1:0] mux_a, mux_b, sel_a, sel_b;
  logic [3:0] an_a, an_b;
  logic [7:0] frame_a, frame_b;
  logic       fv_a, fv_b;

  int errors = 0;
  int checks = 0;

  assign mux_a = map_a[2*sel_a +: 2];
  assign mux_b = map_b[2*sel_b +: 2];

  mux_scan_ctrl #(.DWELL(4), .BLANK(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .digit_mask(mask_a), .mux_o(mux_a),
    .sel(sel_a), .an(an_a), .frame(frame_a), .frame_valid(fv_a));

  mux_scan_ctrl #(.DWELL(1), .BLANK(0), .CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .digit_mask(mask_b), .mux_o(mux_b),
    .sel(sel_b), .an(an_b), .frame(frame_b), .frame_valid(fv_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected an for instance A at cycle idx (0..23) after the enabling edge
  function automatic logic [3:0] exp_an_a(input int idx, input logic [3:0] m);
    logic [3:0] r;
    int k;
    r = 4'hF;
    k = idx / 6;
    if ((idx % 6) >= 2) r[k] = ~m[k];
    return r;
  endfunction

  task automatic test_reset;
    checks++; if (sel_a !== 2'd0) begin errors++; $display("FAIL reset_sel_a got=%h exp=0", sel_a); end
    checks++; if (an_a !== 4'hF) begin errors++; $display("FAIL reset_an_a got=%h exp=F", an_a); end
    checks++; if (frame_a !== 8'h00) begin errors++; $display("FAIL reset_frame_a got=%h exp=00", frame_a); end
    checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL reset_fv_a got=%b exp=0", fv_a); end
    checks++; if ({sel_b, an_b, frame_b, fv_b} !== {2'd0, 4'hF, 8'h00, 1'b0}) begin
      errors++; $display("FAIL reset_b got sel=%h an=%h frame=%h fv=%b", sel_b, an_b, frame_b, fv_b); end
  endtask

  // Two full frames on A from IDLE with the given mask
  task automatic test_scan(input logic [3:0] m, input logic [7:0] prior);
    int idx;
    en_a = 1'b0;
    tick;
    mask_a = m;
    en_a   = 1'b1;
    for (int n = 0; n <= 48; n++) begin
      tick;
      idx = n % 24;
      checks++; if (an_a !== exp_an_a(idx, m)) begin errors++;
        $display("FAIL scan_an n=%0d got=%h exp=%h", n, an_a, exp_an_a(idx, m)); end
      checks++; if (sel_a !== 2'(idx / 6)) begin errors++;
        $display("FAIL scan_sel n=%0d got=%0d exp=%0d", n, sel_a, idx / 6); end
      checks++; if (fv_a !== (n > 0 && idx == 0)) begin errors++;
        $display("FAIL scan_fv n=%0d got=%b", n, fv_a); end
      checks++; if (frame_a !== ((n < 24) ? prior : 8'hE4)) begin errors++;
        $display("FAIL scan_frame n=%0d got=%h exp=%h", n, frame_a, (n < 24) ? prior : 8'hE4); end
    end
  endtask

  task automatic test_no_blank;
    logic [3:0] ea;
    en_b = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      tick;
      ea = 4'hF;
      ea[n % 4] = 1'b0;
      checks++; if (sel_b !== 2'(n % 4)) begin errors++;
        $display("FAIL noblank_sel n=%0d got=%0d exp=%0d", n, sel_b, n % 4); end
      checks++; if (an_b !== ea) begin errors++;
        $display("FAIL noblank_an n=%0d got=%h exp=%h", n, an_b, ea); end
      checks++; if (fv_b !== (n > 0 && n % 4 == 0)) begin errors++;
        $display("FAIL noblank_fv n=%0d got=%b", n, fv_b); end
      checks++; if (frame_b !== ((n < 4) ? 8'h00 : 8'hE4)) begin errors++;
        $display("FAIL noblank_frame n=%0d got=%h", n, frame_b); end
    end
    en_b = 1'b0;
  endtask

  task automatic test_en_drop;
    en_a = 1'b0;
    tick;
    mask_a = 4'hF;
    map_a  = 8'h63;
    en_a   = 1'b1;
    for (int n = 0; n <= 15; n++) tick;
    checks++; if (an_a !== 4'hB) begin errors++; $display("FAIL drop_pre_an got=%h exp=B", an_a); end
    en_a = 1'b0;
    tick;
    checks++; if (an_a !== 4'hF) begin errors++; $display("FAIL drop_an got=%h exp=F", an_a); end
    checks++; if (sel_a !== 2'd0) begin errors++; $display("FAIL drop_sel got=%0d exp=0", sel_a); end
    for (int n = 0; n < 3; n++) begin
      checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL drop_fv n=%0d got=%b", n, fv_a); end
      checks++; if (frame_a !== 8'hE4) begin errors++; $display("FAIL drop_frame got=%h exp=E4", frame_a); end
      tick;
    end
    en_a = 1'b1;
    for (int n = 0; n <= 24; n++) begin
      tick;
      checks++; if (fv_a !== (n == 24)) begin errors++; $display("FAIL restart_fv n=%0d got=%b", n, fv_a); end
      checks++; if (frame_a !== ((n < 24) ? 8'hE4 : 8'h63)) begin errors++;
        $display("FAIL restart_frame n=%0d got=%h", n, frame_a); end
      if (n == 2) begin
        checks++; if (sel_a !== 2'd0 || an_a !== 4'hE) begin errors++;
          $display("FAIL restart_digit0 sel=%0d an=%h", sel_a, an_a); end
      end
    end
  endtask

  // Continues from test_en_drop: A sits at cycle 24 of a running scan
  task automatic test_last_drive;
    map_a = 8'hE4;
    for (int n = 25; n <= 47; n++) begin
      tick;
      checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL last_run_fv n=%0d got=%b", n, fv_a); end
    end
    checks++; if (an_a !== 4'h7 || sel_a !== 2'd3) begin errors++;
      $display("FAIL last_pre an=%h sel=%0d exp an=7 sel=3", an_a, sel_a); end
    en_a = 1'b0;
    tick;
    checks++; if (fv_a !== 1'b0) begin errors++; $display("FAIL last_fv got=%b exp=0", fv_a); end
    checks++; if (frame_a !== 8'h63) begin errors++; $display("FAIL last_frame got=%h exp=63", frame_a); end
    checks++; if (an_a !== 4'hF || sel_a !== 2'd0) begin errors++;
      $display("FAIL last_idle an=%h sel=%0d", an_a, sel_a); end
    tick;
    checks++; if (fv_a !== 1'b0 || frame_a !== 8'h63) begin errors++;
      $display("FAIL last_hold fv=%b frame=%h", fv_a, frame_a); end
  endtask

  task automatic test_async_reset;
    en_a = 1'b1;
    for (int n = 0; n <= 6; n++) tick;
    checks++; if (sel_a !== 2'd1 || an_a !== 4'hF) begin errors++;
      $display("FAIL areset_pre sel=%0d an=%h exp sel=1 an=F", sel_a, an_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sel_a !== 2'd0) begin errors++; $display("FAIL areset_sel got=%0d exp=0", sel_a); end
    checks++; if (frame_a !== 8'h00) begin errors++; $display("FAIL areset_frame got=%h exp=00", frame_a); end
    checks++; if (an_a !== 4'hF || fv_a !== 1'b0) begin errors++;
      $display("FAIL areset_an an=%h fv=%b", an_a, fv_a); end
    for (int n = 0; n < 2; n++) begin
      tick;
      checks++; if ({sel_a, an_a, frame_a, fv_a} !== {2'd0, 4'hF, 8'h00, 1'b0}) begin errors++;
        $display("FAIL areset_hold sel=%0d an=%h frame=%h fv=%b", sel_a, an_a, frame_a, fv_a); end
    end
    rst_n = 1'b1;
    en_a  = 1'b0;
    tick;
  endtask

  initial begin
    rst_n  = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;
    mask_a = 4'hF;
    mask_b = 4'hF;
    map_a  = 8'hE4;
    map_b  = 8'hE4;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    tick;
    test_scan(4'hF, 8'h00);
    test_scan(4'b0101, 8'hE4);
    test_no_blank;
    test_en_drop;
    test_last_drive;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
